// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder, one bit per clock MSB->LSB, with
// valid/ready on both sides and a step check against the previous word.
module gray_to_bin_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_code,
  output logic             step_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LOAD = IW'((WIDTH > 1) ? WIDTH - 2 : 0);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] g_q, prev_q, bin_q;
  logic [IW-1:0]    idx_q;
  logic             have_prev_q, err_q, in_ready_q, out_valid_q;

  logic [WIDTH-1:0] diff_d, bin_up_d;
  logic             err_d;

  // Two or more differing bits <=> clearing the lowest set bit leaves something.
  assign diff_d   = gray_code ^ prev_q;
  assign err_d    = have_prev_q && (|(diff_d & (diff_d - WIDTH'(1))));
  assign bin_up_d = bin_q >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      prev_q      <= '0;
      bin_q       <= '0;
      idx_q       <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            g_q              <= gray_code;
            bin_q[WIDTH-1]   <= gray_code[WIDTH-1];
            prev_q           <= gray_code;
            have_prev_q      <= 1'b1;
            err_q            <= err_d;
            idx_q            <= IDX_LOAD;
            in_ready_q       <= 1'b0;
            if (WIDTH == 1) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= CONV;
            end
          end
        end
        CONV: begin
          bin_q[idx_q] <= bin_up_d[idx_q] ^ g_q[idx_q];
          idx_q        <= idx_q - IW'(1);
          if (idx_q == '0) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_code  = bin_q;
  assign step_err  = err_q;

endmodule
